// File: rtl/shift_mult_if.sv
// Request/result bundle between the ALU multiply decode and the shift-add sequencer.
// The core side drives the operands and start; the sequencer returns product and status.
interface shift_mult_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;
  logic               stall;

  modport master (
    output start, signed_mode, a, b,
    input  product, busy, done, stall
  );

  modport slave (
    input  start, signed_mode, a, b,
    output product, busy, done, stall
  );
endinterface

// File: rtl/shift_mult_sequencer.sv
// Multi-cycle shift-and-add multiplier: one multiplier bit per clock on operand magnitudes,
// followed by a single sign-correction cycle and a one-cycle done pulse.
module shift_mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_mult_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_mcand;
  logic [PW-1:0]     r_product;
  logic [WIDTH-1:0]  r_mplier;
  logic [CNT_W-1:0]  r_count;
  logic              r_neg;
  logic              w_last;
  logic              w_idle;

  // The most negative signed value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v,
                                               input logic          neg);
    return neg ? -v : v;
  endfunction

  assign w_last = (r_count == CNT_W'(WIDTH - 1));
  assign w_idle = (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, magnitude(bus.a, bus.signed_mode)};
            r_mplier <= magnitude(bus.b, bus.signed_mode);
            r_neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CNT_W'(1);
        end
        S_FIX:   r_product <= apply_sign(r_acc, r_neg);
        default: ;
      endcase
    end
  end

  // stall covers the request cycle itself so the core holds the instruction immediately.
  assign bus.product = r_product;
  assign bus.busy    = (r_state == S_RUN) || (r_state == S_FIX);
  assign bus.done    = (r_state == S_DONE);
  assign bus.stall   = bus.busy | (bus.start & w_idle);

endmodule

// File: tb/tb_shift_mult_sequencer.sv
// Directed bench for shift_mult_sequencer: latency, sign handling, corners,
// held start, mid-run reset and start requests ignored while busy.
module tb_shift_mult_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  shift_mult_if #(.WIDTH(32)) bus ();

  shift_mult_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request pulse; checks stall in the request cycle, busy length, latency, result.
  task automatic do_mult(input string tag, input logic sm, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [63:0] exp);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.signed_mode = sm;
    bus.a           = ia;
    bus.b           = ib;
    #1;
    check({tag, "_stall_req"}, 64'(bus.stall), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
    busy_cnt = bus.busy ? 1 : 0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h1357_9BDF;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_busy_len"}, 64'(busy_cnt), 64'd33);
    check({tag, "_product"}, bus.product, exp);
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int d1;
    int d2;
    int ndone;
    logic prev_done;
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a           = '0;
    bus.b           = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_product", bus.product, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and sign handling
    do_mult("u5x4", 1'b0, 32'd5, 32'd4, 64'h0000_0000_0000_0014);
    do_mult("s_m5x4", 1'b1, 32'hFFFF_FFFB, 32'd4, 64'hFFFF_FFFF_FFFF_FFEC);
    do_mult("u_m5x4", 1'b0, 32'hFFFF_FFFB, 32'd4, 64'h0000_0003_FFFF_FFEC);
    do_mult("s_m3xm7", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 64'd21);
    do_mult("s_7xm1", 1'b1, 32'd7, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9);

    // Corners
    do_mult("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_mult("u_max2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    do_mult("zero_a", 1'b0, 32'd0, 32'h0000_1234, 64'd0);

    // start held high: only IDLE-sampled operands count, results every 35 cycles
    @(negedge clk);
    bus.start       = 1'b1;
    bus.signed_mode = 1'b0;
    bus.a           = 32'd2;
    bus.b           = 32'd3;
    @(posedge clk);
    d1 = 0;
    d2 = 0;
    ndone = 0;
    prev_done = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      @(posedge clk);
      #1;
      if (bus.done && prev_done) check("hold_done_twice", 64'd1, 64'd0);
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          d1 = k;
          check("hold_prod1", bus.product, 64'd6);
        end else begin
          d2 = k;
          check("hold_prod2", bus.product, 64'd99);
        end
      end
      prev_done = bus.done;
      @(negedge clk);
      if (k == 5) begin
        bus.a = 32'd1000;
        bus.b = 32'd1000;
      end
      if (k == 30) begin
        bus.a = 32'd9;
        bus.b = 32'd11;
      end
      if (k == 36) begin
        bus.start = 1'b0;
        bus.a     = 32'h0000_FFFF;
        bus.b     = 32'd2;
      end
    end
    check("hold_ndone", 64'(ndone), 64'd2);
    check("hold_d1", 64'(d1), 64'd33);
    check("hold_period", 64'(d2 - d1), 64'd35);

    // Reset at RUN count 10 discards the operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd100;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_product", bus.product, 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("mid_rst_no_done", 64'(ndone), 64'd0);
    check("mid_rst_prod_hold", bus.product, 64'd0);
    do_mult("after_rst", 1'b0, 32'd7, 32'd3, 64'h15);

    // start pulses during RUN and DONE are ignored
    @(negedge clk);
    bus.start       = 1'b1;
    bus.signed_mode = 1'b0;
    bus.a           = 32'd12;
    bus.b           = 32'd13;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 75; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
      @(negedge clk);
      if (k == 5) begin
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end
      if (k == 6)  bus.start = 1'b0;
      if (k == 33) bus.start = 1'b1;
      if (k == 34) bus.start = 1'b0;
    end
    check("ign_ndone", 64'(ndone), 64'd1);
    check("ign_product", bus.product, 64'd156);
    check("ign_idle_busy", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
